// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port memory between the instruction-fetch (IF) port and
// the data-memory (DM) port of a pipelined core. One access is in flight at a
// time. The granted request is latched on entry to a BUSY state, and the
// memory side is driven only from those latched values. Completion is
// reported with a one-cycle valid pulse in the IDLE cycle that follows.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   if_req/if_addr        fetch request and address
//   if_rdata/if_valid     fetched word (held) and completion pulse
//   dm_req/dm_we/dm_addr  data request, store enable, address
//   dm_wdata/dm_amp       store data and byte-lane pattern
//   dm_rdata/dm_valid     load result (held, unchanged by stores) and pulse
//   stall_if/stall_mem    pipeline freeze while a request is outstanding
//   mem_req/mem_we        memory request and write enable
//   mem_addr/mem_wdata    memory address and write data
//   mem_be                memory byte enables
//   mem_ready/mem_rdata   memory completion and read data
//
// Configuration
//   MEM_ARB_RR_EN  when defined, simultaneous requests alternate using a
//                  last-grant flop; otherwise DM always wins a conflict.
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int XLEN      = 32,
    parameter int ADDR_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 if_req,
    input  logic [ADDR_SIZE-1:0] if_addr,
    output logic [XLEN-1:0]      if_rdata,
    output logic                 if_valid,
    input  logic                 dm_req,
    input  logic                 dm_we,
    input  logic [ADDR_SIZE-1:0] dm_addr,
    input  logic [XLEN-1:0]      dm_wdata,
    input  logic [3:0]           dm_amp,
    output logic [XLEN-1:0]      dm_rdata,
    output logic                 dm_valid,
    output logic                 stall_if,
    output logic                 stall_mem,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [XLEN-1:0]      mem_wdata,
    output logic [3:0]           mem_be,
    input  logic                 mem_ready,
    input  logic [XLEN-1:0]      mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } state_t;

    state_t                 state_q;
    logic                   mem_req_q;
    logic                   we_q;
    logic [ADDR_SIZE-1:0]   addr_q;
    logic [XLEN-1:0]        wdata_q;
    logic [3:0]             be_q;
    logic [XLEN-1:0]        if_rdata_q;
    logic [XLEN-1:0]        dm_rdata_q;
    logic                   if_valid_q;
    logic                   dm_valid_q;
    logic                   grant_dm_d;

`ifdef MEM_ARB_RR_EN
    // Remembers who won the last conflict; resets to IF so DM wins the first.
    logic                   last_dm_q;

    always_comb begin
        grant_dm_d = dm_req;
        if (dm_req && if_req) begin
            grant_dm_d = ~last_dm_q;
        end
    end
`else
    always_comb begin
        grant_dm_d = dm_req;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= 4'b0000;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_dm_q  <= 1'b0;
`endif
        end else begin
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            case (state_q)
                // Requests are only looked at here, so a requester that
                // drops or changes its request mid-access has no effect.
                IDLE: begin
                    if (grant_dm_d) begin
                        state_q   <= DM_BUSY;
                        mem_req_q <= 1'b1;
                        we_q      <= dm_we;
                        addr_q    <= dm_addr;
                        wdata_q   <= dm_wdata;
                        be_q      <= dm_amp;
                    end else if (if_req) begin
                        state_q   <= IF_BUSY;
                        mem_req_q <= 1'b1;
                        we_q      <= 1'b0;
                        addr_q    <= if_addr;
                        wdata_q   <= '0;
                        be_q      <= 4'b1111;
                    end
`ifdef MEM_ARB_RR_EN
                    // Only conflicts move the pointer, so lone accesses do
                    // not disturb the alternation.
                    if (dm_req && if_req) begin
                        last_dm_q <= grant_dm_d;
                    end
`endif
                end
                IF_BUSY: begin
                    if (mem_ready) begin
                        state_q    <= IDLE;
                        mem_req_q  <= 1'b0;
                        if_valid_q <= 1'b1;
                        if_rdata_q <= mem_rdata;
                    end
                end
                DM_BUSY: begin
                    if (mem_ready) begin
                        state_q    <= IDLE;
                        mem_req_q  <= 1'b0;
                        dm_valid_q <= 1'b1;
                        if (!we_q) begin
                            dm_rdata_q <= mem_rdata;
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_valid  = if_valid_q;
    assign dm_valid  = dm_valid_q;
    assign stall_if  = if_req & ~if_valid_q;
    assign stall_mem = dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Bench for mem_arbiter: a table of lone transactions, hand-written
// sequences for conflicts, back-to-back fetches, dropped requests and reset
// mid-access, then randomized traffic against a transaction-level model.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_amp;
    logic [31:0] dm_rdata;
    logic        dm_valid;
    logic        stall_if;
    logic        stall_mem;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(.XLEN(32), .ADDR_SIZE(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_valid (if_valid),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_amp   (dm_amp),
        .dm_rdata (dm_rdata),
        .dm_valid (dm_valid),
        .stall_if (stall_if),
        .stall_mem(stall_mem),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_be   (mem_be),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    typedef struct {
        bit          is_dm;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  amp;
        int          delay;
        logic [31:0] rdata;
        logic [3:0]  exp_be;
        bit          exp_we;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs [6];

    // Transaction-level reference for the random phase.
    int          m_owner;      // 0 none, 1 fetch, 2 data
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    bit          m_we;
    bit          m_ifv;
    bit          m_dmv;
    logic [31:0] m_ifr;
    logic [31:0] m_dmr;
    bit          m_last_dm;
    logic [3:0]  amps [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int  cyc;
        int  busy;
        bit  got;
        bit  vld;
        if (v.is_dm) begin
            dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr;
            dm_wdata = v.wdata; dm_amp = v.amp;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        mem_ready = 1'b0;
        #1;
        chk($sformatf("vec%0d_stall_c0", idx), v.is_dm ? stall_mem : stall_if, 1'b1);
        cyc = 0; busy = 0; got = 0;
        while (!got && cyc < 30) begin
            step();
            cyc++;
            vld = v.is_dm ? dm_valid : if_valid;
            if (vld) begin
                got = 1;
                chk($sformatf("vec%0d_latency", idx), cyc, v.exp_lat);
                chk($sformatf("vec%0d_rdata", idx), v.is_dm ? dm_rdata : if_rdata, v.exp_rdata);
                chk($sformatf("vec%0d_stall_done", idx), v.is_dm ? stall_mem : stall_if, 1'b0);
                if_req = 1'b0; dm_req = 1'b0; mem_ready = 1'b0;
            end else if (mem_req) begin
                chk($sformatf("vec%0d_be", idx), mem_be, v.exp_be);
                chk($sformatf("vec%0d_we", idx), mem_we, v.exp_we);
                chk($sformatf("vec%0d_addr", idx), mem_addr, v.addr);
                if (v.exp_we) chk($sformatf("vec%0d_wdata", idx), mem_wdata, v.wdata);
                mem_ready = (busy == v.delay);
                mem_rdata = mem_ready ? v.rdata : $urandom;
                busy++;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
            end
        end
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL vec%0d_timeout: no valid within 30 cycles", idx);
            if_req = 1'b0; dm_req = 1'b0; mem_ready = 1'b0;
        end
        chk($sformatf("vec%0d_busy_cycles", idx), busy, v.delay + 1);
        step();
        chk($sformatf("vec%0d_single_pulse", idx), {if_valid, dm_valid}, 2'b00);
    endtask

    task automatic conflict(input bit dm_first, input string tag);
        if_req = 1'b1; if_addr = 32'h40;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100; dm_amp = 4'b1111;
        mem_ready = 1'b0;
        step();
        chk({tag, "_req1"}, mem_req, 1'b1);
        chk({tag, "_addr1"}, mem_addr, dm_first ? 32'h100 : 32'h40);
        mem_ready = 1'b1; mem_rdata = 32'h5555AAAA;
        step();
        if (dm_first) begin
            chk({tag, "_valid1"}, {dm_valid, if_valid}, 2'b10);
            dm_req = 1'b0;
        end else begin
            chk({tag, "_valid1"}, {dm_valid, if_valid}, 2'b01);
            if_req = 1'b0;
        end
        mem_ready = 1'b0;
        step();
        chk({tag, "_req2"}, mem_req, 1'b1);
        chk({tag, "_addr2"}, mem_addr, dm_first ? 32'h40 : 32'h100);
        mem_ready = 1'b1; mem_rdata = 32'h3333CCCC;
        step();
        chk({tag, "_valid2"}, {dm_valid, if_valid}, dm_first ? 2'b01 : 2'b10);
        if_req = 1'b0; dm_req = 1'b0; mem_ready = 1'b0;
        step();
    endtask

    initial begin
        bit nifv;
        bit ndmv;
        bit pick_dm;

        vecs[0] = '{0, 0, 32'h40,  32'h0,        4'b1111, 0, 32'h00500093, 4'b1111, 0, 32'h00500093, 2};
        vecs[1] = '{1, 0, 32'h100, 32'h0,        4'b1111, 1, 32'hDEADBEEF, 4'b1111, 0, 32'hDEADBEEF, 3};
        vecs[2] = '{1, 1, 32'h203, 32'hAB000000, 4'b1000, 3, 32'h12345678, 4'b1000, 1, 32'hDEADBEEF, 5};
        vecs[3] = '{1, 0, 32'h302, 32'h0,        4'b1100, 0, 32'hCAFE0000, 4'b1100, 0, 32'hCAFE0000, 2};
        vecs[4] = '{0, 0, 32'h44,  32'h0,        4'b1111, 2, 32'h11223344, 4'b1111, 0, 32'h11223344, 4};
        vecs[5] = '{1, 1, 32'h10,  32'h0000BEEF, 4'b0011, 0, 32'h99999999, 4'b0011, 1, 32'hCAFE0000, 2};
        amps = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

        reset = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
        dm_addr = '0; dm_wdata = '0; dm_amp = '0; mem_ready = 1'b0; mem_rdata = '0;
        step(); step();
        reset = 1'b0;
        #1;
        chk("rst_ctrl", {mem_req, mem_we, mem_be, if_valid, dm_valid, stall_if, stall_mem}, 10'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_dm_rdata", dm_rdata, 32'h0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        conflict(1'b1, "conflict_a");
`ifdef MEM_ARB_RR_EN
        conflict(1'b0, "conflict_b");
`else
        conflict(1'b1, "conflict_b");
`endif

        // Back-to-back fetches with the memory always ready.
        if_req = 1'b1; if_addr = 32'h0; mem_ready = 1'b1; mem_rdata = 32'h00000013;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) step(); else #1;
            chk($sformatf("b2b_req_c%0d", c), mem_req, (c == 1 || c == 3));
            chk($sformatf("b2b_valid_c%0d", c), if_valid, (c == 2 || c == 4));
            if (c == 3) chk("b2b_addr2", mem_addr, 32'h4);
            if (c == 2) if_addr = 32'h4;
            if (c == 4) if_req = 1'b0;
        end

        // mem_ready while idle must do nothing.
        mem_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("idle_ready_c%0d", c), {mem_req, if_valid, dm_valid}, 3'b000);
        end

        // Requester drops its request during the access.
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h80; dm_wdata = 32'h0F0F0F0F;
        dm_amp = 4'b1111; mem_ready = 1'b0;
        step();
        chk("drop_req_c1", mem_req, 1'b1);
        dm_req = 1'b0;
        step();
        chk("drop_busy_c2", {mem_req, dm_valid}, 2'b10);
        mem_ready = 1'b1;
        step();
        chk("drop_valid_c3", dm_valid, 1'b1);
        mem_ready = 1'b0;
        step();
        chk("drop_idle_c4", {mem_req, dm_valid}, 2'b00);

        // Reset during a data access with the memory stalled.
        chk("pre_reset_dm_rdata_set", (dm_rdata != 32'h0), 1'b1);
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100; dm_amp = 4'b1111; mem_ready = 1'b0;
        step();
        chk("rstmid_busy", mem_req, 1'b1);
        reset = 1'b1;
        step();
        chk("rstmid_ctrl", {mem_req, dm_valid, if_valid, mem_be}, 7'd0);
        chk("rstmid_dm_rdata", dm_rdata, 32'h0);
        chk("rstmid_if_rdata", if_rdata, 32'h0);
        chk("rstmid_addr", mem_addr, 32'h0);
        reset = 1'b0; dm_req = 1'b0; mem_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("rstmid_after_c%0d", c), {mem_req, dm_valid}, 2'b00);
        end
        mem_ready = 1'b0;

        // Randomized traffic; reference state starts from the reset above.
        m_owner = 0; m_ifv = 0; m_dmv = 0; m_ifr = '0; m_dmr = '0; m_last_dm = 0;
        m_addr = '0; m_wdata = '0; m_be = '0; m_we = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            chk("rnd_mem_req", mem_req, (m_owner != 0));
            if (m_owner != 0) begin
                chk("rnd_mem_addr", mem_addr, m_addr);
                chk("rnd_mem_we", mem_we, m_we);
                chk("rnd_mem_be", mem_be, m_be);
                if (m_we) chk("rnd_mem_wdata", mem_wdata, m_wdata);
            end
            chk("rnd_if_valid", if_valid, m_ifv);
            chk("rnd_dm_valid", dm_valid, m_dmv);
            chk("rnd_if_rdata", if_rdata, m_ifr);
            chk("rnd_dm_rdata", dm_rdata, m_dmr);

            // Requesters: hold until completion, then maybe issue again.
            if (!if_req || m_ifv) begin
                if_req = ($urandom_range(2) == 0);
                if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!dm_req || m_dmv) begin
                dm_req = ($urandom_range(2) == 0);
                dm_we = $urandom_range(1);
                dm_addr = $urandom;
                dm_wdata = $urandom;
                dm_amp = amps[$urandom_range(6)];
            end
            mem_ready = $urandom_range(1);
            mem_rdata = $urandom;
            #1;
            chk("rnd_stall_if", stall_if, if_req & ~m_ifv);
            chk("rnd_stall_mem", stall_mem, dm_req & ~m_dmv);

            // Reference: an access completes when the memory answers; a free
            // memory takes the winning pending request.
            nifv = 0; ndmv = 0;
            if (m_owner != 0) begin
                if (mem_ready) begin
                    if (m_owner == 1) begin
                        nifv = 1; m_ifr = mem_rdata;
                    end else begin
                        ndmv = 1;
                        if (!m_we) m_dmr = mem_rdata;
                    end
                    m_owner = 0;
                end
            end else if (if_req || dm_req) begin
                pick_dm = dm_req;
`ifdef MEM_ARB_RR_EN
                if (if_req && dm_req) begin
                    pick_dm = !m_last_dm;
                    m_last_dm = pick_dm;
                end
`endif
                if (pick_dm) begin
                    m_owner = 2; m_addr = dm_addr; m_we = dm_we;
                    m_wdata = dm_wdata; m_be = dm_amp;
                end else begin
                    m_owner = 1; m_addr = if_addr; m_we = 0; m_be = 4'b1111;
                end
            end
            m_ifv = nifv; m_dmv = ndmv;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
